rom_bus_arbiter: RTL

ROM_BUS_ARBITER -- requirements
Module: rom_bus_arbiter

---
 rtl/rom_arb_pkg.sv | 20 ++
 rtl/rom_bus_arbiter_if.sv | 37 +++
 rtl/rom_bus_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM bus arbiter.
// Holds the FSM state, wait-count constants and grant encoding.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'b00,
    GNT_FETCH = 2'b01,
    GNT_BUF   = 2'b10
  } gnt_e;

  localparam logic [2:0] FAST_WAIT = 3'd2;
  localparam logic [2:0] SLOW_WAIT = 3'd4;

endpackage

// File: rtl/rom_bus_arbiter_if.sv
// ROM bus arbiter interface: host/GSU control, requesters, ROM side.
// master drives requests and ROM data, slave is the arbiter.
interface rom_bus_arbiter_if;

  logic        ron;
  logic        clsr;
  logic [23:0] ha;
  logic        fetch_req;
  logic [23:0] fetch_a;
  logic        buf_req;
  logic [23:0] buf_a;
  logic        fetch_rdy;
  logic        buf_rdy;
  logic [23:0] rom_a;
  logic [7:0]  rom_d;
  logic [7:0]  rom_q;
  logic        busy;

  modport master (
    output ron, clsr, ha,
    output fetch_req, fetch_a,
    output buf_req, buf_a,
    output rom_d,
    input  fetch_rdy, buf_rdy,
    input  rom_a, rom_q, busy
  );

  modport slave (
    input  ron, clsr, ha,
    input  fetch_req, fetch_a,
    input  buf_req, buf_a,
    input  rom_d,
    output fetch_rdy, buf_rdy,
    output rom_a, rom_q, busy
  );

endinterface

// File: rtl/rom_bus_arbiter.sv
// ROM bus arbiter: host forwarding or GSU fetch/buffer grants.
// ROMARB_ROUND_ROBIN_EN swaps fixed priority for alternation.
module rom_bus_arbiter
  import rom_arb_pkg::*;
(
  input logic              clk,
  input logic              reset,
  rom_bus_arbiter_if.slave bus
);

  state_e     state;
  gnt_e       gnt;
  gnt_e       pick;
  logic [2:0] cnt;

`ifdef ROMARB_ROUND_ROBIN_EN
  logic pref_buf;
`endif

  always_comb begin
    pick = GNT_NONE;
    if (bus.fetch_req && bus.buf_req) begin
`ifdef ROMARB_ROUND_ROBIN_EN
      pick = pref_buf ? GNT_BUF : GNT_FETCH;
`else
      pick = GNT_FETCH;
`endif
    end else if (bus.fetch_req) begin
      pick = GNT_FETCH;
    end else if (bus.buf_req) begin
      pick = GNT_BUF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      gnt           <= GNT_NONE;
      cnt           <= 3'd0;
      bus.rom_a     <= 24'h000000;
      bus.rom_q     <= 8'h00;
      bus.fetch_rdy <= 1'b0;
      bus.buf_rdy   <= 1'b0;
      bus.busy      <= 1'b0;
`ifdef ROMARB_ROUND_ROBIN_EN
      pref_buf      <= 1'b0;
`endif
    end else begin
      bus.fetch_rdy <= 1'b0;
      bus.buf_rdy   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!bus.ron) begin
            bus.rom_a <= bus.ha;
          end else if (pick != GNT_NONE) begin
            gnt       <= pick;
            bus.rom_a <= (pick == GNT_BUF) ? bus.buf_a
                                           : bus.fetch_a;
            cnt       <= bus.clsr ? FAST_WAIT : SLOW_WAIT;
            state     <= ACCESS;
            bus.busy  <= 1'b1;
`ifdef ROMARB_ROUND_ROBIN_EN
            pref_buf  <= (pick == GNT_FETCH);
`endif
          end
        end
        ACCESS: begin
          if (cnt == 3'd0) begin
            bus.rom_q     <= bus.rom_d;
            bus.fetch_rdy <= (gnt == GNT_FETCH);
            bus.buf_rdy   <= (gnt == GNT_BUF);
            state         <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          gnt      <= GNT_NONE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          gnt      <= GNT_NONE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
